// File: rtl/cr_prefix_pfq.sv
// Prefix-result queue: encodes prefix engine results into 9-bit entries and
// buffers them in a first-word-fall-through FIFO with a registered head.
module cr_prefix_pfq #(
    parameter int DEPTH      = 8,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pe_res_valid,
    output logic                       pe_res_ready,
    input  logic [5:0]                 pe_res_num,
    input  logic                       pe_res_err,
    input  logic [7:0]                 pe_res_code,
    input  logic                       pfq_flush,
    output logic [8:0]                 pf_data,
    output logic                       pf_empty,
    output logic                       pf_aempty,
    input  logic                       obc_pf_ren,
    output logic [$clog2(DEPTH):0]     pfq_count,
    output logic [$clog2(DEPTH):0]     pfq_hwm,
    output logic                       pfq_uflow,
    output logic                       pfq_err_evt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LVL);
    localparam logic [CW-1:0] ONE_CNT    = CW'(1);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] hwm_reg, hwm_next;
    logic [8:0]    pf_data_reg, pf_data_next;
    logic          uflow_reg, err_evt_reg;

    logic          full, empty;
    logic          push, pop;
    logic [8:0]    entry;
    logic [AW-1:0] rd_ptr_inc;

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == FULL_CNT);
    assign pe_res_ready = ~full;
    assign pf_empty     = empty;
    assign pf_aempty    = (count_reg <= AEMPTY_CNT);
    assign pf_data      = pf_data_reg;
    assign pfq_count    = count_reg;
    assign pfq_hwm      = hwm_reg;
    assign pfq_uflow    = uflow_reg;
    assign pfq_err_evt  = err_evt_reg;

    // Flush wins over both sides of the handshake for the cycle it is asserted.
    assign push  = pe_res_valid & ~full & ~pfq_flush;
    assign pop   = obc_pf_ren & ~empty & ~pfq_flush;
    assign entry = pe_res_err ? {1'b1, pe_res_code} : {3'b000, pe_res_num};
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        pf_data_next = pf_data_reg;
        if (pfq_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_next = rd_ptr_inc;
            if (push && !pop)      count_next = count_reg + ONE_CNT;
            else if (pop && !push) count_next = count_reg - ONE_CNT;
            // Head register: the next entry comes from memory unless it is
            // the one being written this very cycle.
            if (push && empty) begin
                pf_data_next = entry;
            end else if (pop) begin
                if (count_reg == ONE_CNT) begin
                    if (push) pf_data_next = entry;
                end else begin
                    pf_data_next = mem[rd_ptr_inc];
                end
            end
        end
        hwm_next = pfq_flush ? '0 : ((count_next > hwm_reg) ? count_next : hwm_reg);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            hwm_reg     <= '0;
            pf_data_reg <= '0;
            uflow_reg   <= 1'b0;
            err_evt_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            hwm_reg     <= hwm_next;
            pf_data_reg <= pf_data_next;
            err_evt_reg <= push & pe_res_err;
            if (obc_pf_ren && empty) uflow_reg <= 1'b1;
        end
    end
endmodule
